// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data memory with valid/ready request/response
// handshake, byte/half/word accesses and a fixed number of wait states.
module data_mem_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          AW       = $clog2(DEPTH_BYTES);
    localparam logic [32:0] DEPTH33  = 33'(DEPTH_BYTES);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("data_mem_ctrl: DATA_WIDTH must be 32");
        end
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("data_mem_ctrl: LATENCY must be in 1..15");
        end
        if (DEPTH_BYTES < 4 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
            $error("data_mem_ctrl: DEPTH_BYTES must be a power of two >= 4");
        end
    endgenerate

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [7:0]  r_mem [DEPTH_BYTES];

    logic          w_commit;
    logic [32:0]   w_bytes;
    logic [32:0]   w_end;
    logic          w_err;
    logic [AW-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0]    w_b0, w_b1, w_b2, w_b3;
    logic [31:0]   w_load;

    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);

    // End address is formed at 33 bits so accesses near 2^32 cannot wrap into range.
    assign w_bytes = (r_size == 2'b10) ? 33'd4 : (r_size == 2'b01) ? 33'd2 : 33'd1;
    assign w_end   = {1'b0, r_addr} + w_bytes;
    assign w_err   = (r_size == 2'b11)
                   || ((r_size == 2'b01) && r_addr[0])
                   || ((r_size == 2'b10) && (r_addr[1:0] != 2'b00))
                   || (w_end > DEPTH33);

    assign w_a0 = r_addr[AW-1:0];
    assign w_a1 = w_a0 + AW'(1);
    assign w_a2 = w_a0 + AW'(2);
    assign w_a3 = w_a0 + AW'(3);
    assign w_b0 = r_mem[w_a0];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    always_comb begin
        w_load = '0;
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_b0[7]}}, w_b0};
            2'b01:   w_load = {{16{r_signed & w_b0[7]}}, w_b0, w_b1};
            2'b10:   w_load = {w_b0, w_b1, w_b2, w_b3};
            default: w_load = '0;
        endcase
    end

    // The array has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_commit && r_write && !w_err) begin
            case (r_size)
                2'b00: r_mem[w_a0] <= r_wdata[7:0];
                2'b01: begin
                    r_mem[w_a0] <= r_wdata[15:8];
                    r_mem[w_a1] <= r_wdata[7:0];
                end
                2'b10: begin
                    r_mem[w_a0] <= r_wdata[31:24];
                    r_mem[w_a1] <= r_wdata[23:16];
                    r_mem[w_a2] <= r_wdata[15:8];
                    r_mem[w_a3] <= r_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_write  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_cnt    <= CNT_INIT;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_err   <= w_err;
                        r_rdata <= (r_write || w_err) ? 32'd0 : w_load;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state == S_WAIT) || (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: three instances (LATENCY 2, 4, 1)
// checked against a byte-array reference model of the big-endian memory.
module tb_data_mem_ctrl;

    localparam int DEPTH = 1024;

    logic        clk;
    logic [2:0]  rstN;
    logic        reqValid [3];
    logic        reqReady [3];
    logic        rspValid [3];
    logic        rspReady [3];
    logic [31:0] rspRdata [3];
    logic        rspErr   [3];
    logic        busyO    [3];
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;

    int latOf [3] = '{2, 4, 1};

    data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(2), .DATA_WIDTH(32)) dut0 (
        .clk(clk), .rst_n(rstN[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .req_write(reqWrite), .req_size(reqSize), .req_signed(reqSigned),
        .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rspValid[0]),
        .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0]),
        .busy(busyO[0]));

    data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(4), .DATA_WIDTH(32)) dut1 (
        .clk(clk), .rst_n(rstN[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .req_write(reqWrite), .req_size(reqSize), .req_signed(reqSigned),
        .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rspValid[1]),
        .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1]),
        .busy(busyO[1]));

    data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(1), .DATA_WIDTH(32)) dut2 (
        .clk(clk), .rst_n(rstN[2]), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
        .req_write(reqWrite), .req_size(reqSize), .req_signed(reqSigned),
        .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rspValid[2]),
        .rsp_ready(rspReady[2]), .rsp_rdata(rspRdata[2]), .rsp_err(rspErr[2]),
        .busy(busyO[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: one byte array per instance plus a written-yet flag.
    logic [7:0] refMem [3][DEPTH];
    bit         known  [3][DEPTH];

    logic [31:0] obsRdata;
    logic        obsErr;
    logic        obsBusy;
    logic        obsIdle;
    logic        gotRsp;
    int          obsLat;
    int          obsLow;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit modelErr(input int size, input longint addr);
        int n;
        if (size == 3) return 1'b1;
        n = 1 << size;
        if ((addr % n) != 0) return 1'b1;
        if (addr + n > DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit modelKnown(input int d, input int size, input int addr);
        for (int i = 0; i < (1 << size); i++)
            if (!known[d][addr + i]) return 1'b0;
        return 1'b1;
    endfunction

    // Big-endian assembly, then arithmetic sign extension of the n-byte value.
    function automatic logic [31:0] modelLoad(input int d, input int size, input bit sgn, input int addr);
        int n = 1 << size;
        longint v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | longint'(refMem[d][addr + i]);
        if (sgn && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic modelStore(input int d, input int size, input int addr, input logic [31:0] wd);
        int n = 1 << size;
        for (int i = 0; i < n; i++) begin
            refMem[d][addr + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
            known[d][addr + i]  = 1'b1;
        end
    endtask

    task automatic applyStimulus(input string tag, input int d, input bit wr, input int size,
                                 input bit sgn, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        checkOutput({tag, "_ready"}, 32'(reqReady[d]), 32'd1);
        reqWrite    = wr;
        reqSize     = 2'(size);
        reqSigned   = sgn;
        reqAddr     = addr;
        reqWdata    = wd;
        rspReady[d] = 1'b1;
        reqValid[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[d] = 1'b0;
        obsBusy = busyO[d];
        gotRsp  = 1'b0;
        obsLat  = 0;
        obsLow  = 0;
        obsIdle = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (!reqReady[d]) obsLow++;
            if (rspValid[d]) begin
                gotRsp = 1'b1;
                obsLat = k - 1;
                break;
            end
            @(negedge clk);
        end
        obsRdata = rspRdata[d];
        obsErr   = rspErr[d];
        if (gotRsp) begin
            @(negedge clk);
            obsIdle = reqReady[d] && !rspValid[d];
        end
    endtask

    task automatic runAndCheck(input string tag, input int d, input bit wr, input int size,
                               input bit sgn, input logic [31:0] addr, input logic [31:0] wd);
        bit e;
        applyStimulus(tag, d, wr, size, sgn, addr, wd);
        checkOutput({tag, "_gotrsp"}, 32'(gotRsp), 32'd1);
        checkOutput({tag, "_lat"}, 32'(obsLat), 32'(latOf[d]));
        checkOutput({tag, "_readylow"}, 32'(obsLow), 32'(latOf[d] + 1));
        checkOutput({tag, "_busy"}, 32'(obsBusy), 32'd1);
        checkOutput({tag, "_idle"}, 32'(obsIdle), 32'd1);
        e = modelErr(size, longint'(addr));
        checkOutput({tag, "_err"}, 32'(obsErr), 32'(e));
        if (e || wr) begin
            checkOutput({tag, "_rdata0"}, obsRdata, 32'd0);
            if (!e) modelStore(d, size, int'(addr), wd);
        end else if (modelKnown(d, size, int'(addr))) begin
            checkOutput({tag, "_rdata"}, obsRdata, modelLoad(d, size, sgn, int'(addr)));
        end
    endtask

    initial begin
        logic [31:0] holdRdata;
        logic        holdErr;
        logic        busyBefore;
        int          sz;
        int          nb;
        logic [31:0] ad;

        rstN      = 3'b111;
        reqWrite  = 1'b0;
        reqSize   = 2'b00;
        reqSigned = 1'b0;
        reqAddr   = '0;
        reqWdata  = '0;
        for (int i = 0; i < 3; i++) begin
            reqValid[i] = 1'b0;
            rspReady[i] = 1'b1;
        end
        #1 rstN = 3'b000;
        #1;
        checkOutput("rst_ready", 32'(reqReady[0]), 32'd1);
        checkOutput("rst_rspvalid", 32'(rspValid[0]), 32'd0);
        checkOutput("rst_rdata", rspRdata[0], 32'd0);
        checkOutput("rst_err", 32'(rspErr[0]), 32'd0);
        checkOutput("rst_busy", 32'(busyO[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstN = 3'b111;

        // Word store/load and big-endian byte lanes.
        runAndCheck("st8", 0, 1, 2, 0, 32'd8, 32'hAABBCCDD);
        runAndCheck("ld8", 0, 0, 2, 0, 32'd8, 32'h0);
        checkOutput("ld8_lit", obsRdata, 32'hAABBCCDD);
        runAndCheck("lb8", 0, 0, 0, 0, 32'd8, 32'h0);
        checkOutput("lb8_lit", obsRdata, 32'h000000AA);
        runAndCheck("lb9", 0, 0, 0, 0, 32'd9, 32'h0);
        checkOutput("lb9_lit", obsRdata, 32'h000000BB);
        runAndCheck("lb10", 0, 0, 0, 0, 32'd10, 32'h0);
        checkOutput("lb10_lit", obsRdata, 32'h000000CC);
        runAndCheck("lb11", 0, 0, 0, 0, 32'd11, 32'h0);
        checkOutput("lb11_lit", obsRdata, 32'h000000DD);

        // Extension rules.
        runAndCheck("st16", 0, 1, 2, 0, 32'd16, 32'h80FF1234);
        runAndCheck("lbu16", 0, 0, 0, 0, 32'd16, 32'h0);
        checkOutput("lbu16_lit", obsRdata, 32'h00000080);
        runAndCheck("lbs16", 0, 0, 0, 1, 32'd16, 32'h0);
        checkOutput("lbs16_lit", obsRdata, 32'hFFFFFF80);
        runAndCheck("lhs18", 0, 0, 1, 1, 32'd18, 32'h0);
        checkOutput("lhs18_lit", obsRdata, 32'h00001234);
        runAndCheck("lhs16", 0, 0, 1, 1, 32'd16, 32'h0);
        checkOutput("lhs16_lit", obsRdata, 32'hFFFF80FF);

        // Partial stores only touch the covered lanes, taken from the low wdata bytes.
        runAndCheck("sb17", 0, 1, 0, 0, 32'd17, 32'hABCDEF11);
        runAndCheck("lw16a", 0, 0, 2, 0, 32'd16, 32'h0);
        checkOutput("lw16a_lit", obsRdata, 32'h80111234);
        runAndCheck("sh18", 0, 1, 1, 0, 32'd18, 32'h1234BEEF);
        runAndCheck("lw16b", 0, 0, 2, 0, 32'd16, 32'h0);
        checkOutput("lw16b_lit", obsRdata, 32'h8011BEEF);

        // Faults.
        runAndCheck("st4", 0, 1, 2, 0, 32'd4, 32'h01020304);
        runAndCheck("sw6", 0, 1, 2, 0, 32'd6, 32'hDEADBEEF);
        checkOutput("sw6_err_lit", 32'(obsErr), 32'd1);
        runAndCheck("lw4", 0, 0, 2, 0, 32'd4, 32'h0);
        checkOutput("lw4_lit", obsRdata, 32'h01020304);
        runAndCheck("lh3", 0, 0, 1, 0, 32'd3, 32'h0);
        runAndCheck("sw1020", 0, 1, 2, 0, 32'd1020, 32'h5A5AA5A5);
        runAndCheck("lw1020", 0, 0, 2, 0, 32'd1020, 32'h0);
        checkOutput("lw1020_lit", obsRdata, 32'h5A5AA5A5);
        runAndCheck("lw1021", 0, 0, 2, 0, 32'd1021, 32'h0);
        runAndCheck("lb1024", 0, 0, 0, 0, 32'd1024, 32'h0);
        checkOutput("lb1024_err_lit", 32'(obsErr), 32'd1);
        runAndCheck("sz11", 0, 1, 3, 0, 32'd0, 32'hFFFFFFFF);
        runAndCheck("ffff", 0, 0, 2, 0, 32'hFFFFFFFC, 32'h0);

        // Backpressure: response held while a conflicting store request is offered.
        @(negedge clk);
        reqWrite    = 1'b0;
        reqSize     = 2'b10;
        reqSigned   = 1'b0;
        reqAddr     = 32'd16;
        rspReady[0] = 1'b0;
        reqValid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        gotRsp = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rspValid[0]) begin
                gotRsp = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("bp_gotrsp", 32'(gotRsp), 32'd1);
        holdRdata = rspRdata[0];
        holdErr   = rspErr[0];
        checkOutput("bp_rdata_lit", holdRdata, 32'h8011BEEF);
        for (int k = 0; k < 5; k++) begin
            reqWrite    = 1'b1;
            reqWdata    = 32'h55555555;
            reqValid[0] = 1'b1;
            @(negedge clk);
            checkOutput("bp_valid", 32'(rspValid[0]), 32'd1);
            checkOutput("bp_rdata", rspRdata[0], holdRdata);
            checkOutput("bp_err", 32'(rspErr[0]), 32'(holdErr));
            checkOutput("bp_noaccept", 32'(reqReady[0]), 32'd0);
        end
        rspReady[0] = 1'b1;
        @(negedge clk);
        reqValid[0] = 1'b0;
        checkOutput("bp_done_valid", 32'(rspValid[0]), 32'd0);
        checkOutput("bp_done_ready", 32'(reqReady[0]), 32'd1);
        runAndCheck("bp_after", 0, 0, 2, 0, 32'd16, 32'h0);
        checkOutput("bp_after_lit", obsRdata, 32'h8011BEEF);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            nb = (sz == 3) ? 1 : (1 << sz);
            ad = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 63) : $urandom_range(0, 1031);
            if ($urandom_range(0, 3) != 0) ad = ad - (ad % nb);
            runAndCheck("rnd", 0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                        ad, $urandom);
        end

        // Reset during WAIT aborts the store (LATENCY 4 instance).
        runAndCheck("r_st32", 1, 1, 2, 0, 32'd32, 32'hCAFEF00D);
        @(negedge clk);
        reqWrite    = 1'b1;
        reqSize     = 2'b10;
        reqAddr     = 32'd32;
        reqWdata    = 32'h12345678;
        reqValid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[1] = 1'b0;
        @(negedge clk);
        busyBefore = busyO[1];
        checkOutput("r_busy_before", 32'(busyBefore), 32'd1);
        #2 rstN[1] = 1'b0;
        #1;
        checkOutput("r_ready", 32'(reqReady[1]), 32'd1);
        checkOutput("r_rspvalid", 32'(rspValid[1]), 32'd0);
        checkOutput("r_rdata", rspRdata[1], 32'd0);
        checkOutput("r_err", 32'(rspErr[1]), 32'd0);
        checkOutput("r_busy", 32'(busyO[1]), 32'd0);
        @(negedge clk);
        rstN[1] = 1'b1;
        runAndCheck("r_ld32", 1, 0, 2, 0, 32'd32, 32'h0);
        checkOutput("r_ld32_lit", obsRdata, 32'hCAFEF00D);

        // LATENCY 1 instance.
        runAndCheck("l1_st", 2, 1, 1, 0, 32'd100, 32'h0000C3A5);
        runAndCheck("l1_ld", 2, 0, 1, 1, 32'd100, 32'h0);
        checkOutput("l1_ld_lit", obsRdata, 32'hFFFFC3A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
